tdc_timestamp: RTL

TDC_TIMESTAMP -- requirements
Module: tdc_timestamp

---
 rtl/tdc_pkg.sv | 21 ++
 rtl/ts_fifo.sv | 63 ++++++
 rtl/tdc_timestamp.sv | 108 ++++++++++
 3 files changed

// File: rtl/tdc_pkg.sv
// Shared widths, state encoding and a saturating-counter helper for the
// TDC timestamp path.
package tdc_pkg;

    localparam int COARSE_W = 24;
    localparam int FINE_W   = 8;
    localparam int TS_W     = COARSE_W + FINE_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } tdc_state_e;

    // At most two hits are lost in any one cycle, so a 2-bit increment is enough.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/ts_fifo.sv
// First-word-fall-through timestamp FIFO. dout and empty come straight from
// registers; dout keeps the last head value while the FIFO is empty.
module ts_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, rd_next;
    logic [AW:0]      count, count_next;
    logic             valid_q;
    logic             push_ok, pop_ok;
    logic [WIDTH-1:0] head_next;

    assign empty   = ~valid_q;
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop && valid_q;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);

    assign rd_next    = rd_ptr + AW'(pop_ok);
    assign count_next = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    // The new head is the incoming word only when it lands on the next read slot.
    assign head_next  = (push_ok && (wr_ptr == rd_next)) ? din : mem[rd_next];

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
            dout    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr  <= rd_next;
            count   <= count_next;
            valid_q <= (count_next != '0);
            if (count_next != '0) begin
                dout <= head_next;
            end
        end
    end

endmodule

// File: rtl/tdc_timestamp.sv
// Pairs each hit's coarse time with the fine code from the decode stage and
// queues the {coarse, fine} timestamp; lost hits are counted in drop_count.
module tdc_timestamp #(
    parameter int COARSE_W   = tdc_pkg::COARSE_W,
    parameter int FINE_W     = tdc_pkg::FINE_W,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hit_go,
    input  logic                       dec_finished,
    input  logic [FINE_W-1:0]          dec_code,
    output logic [COARSE_W+FINE_W-1:0] ts_data,
    output logic                       ts_valid,
    input  logic                       ts_ready,
    output logic                       busy,
    output logic                       overflow,
    output logic [15:0]                drop_count
);

    import tdc_pkg::*;

    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    tdc_state_e          state, state_next;
    logic [COARSE_W-1:0] coarse, coarse_lat, coarse_lat_next;
    logic [WCNT_W-1:0]   wait_cnt, wait_cnt_next;
    logic                fsm_push;
    logic [1:0]          fsm_drops;
    logic                fifo_empty, fifo_full, pop, lost;
    logic [1:0]          drop_inc;

    // Handshake: an entry transfers on every clk edge where ts_valid && ts_ready;
    // ts_data/ts_valid are registered and never look at ts_ready.
    assign pop      = ts_valid && ts_ready;
    assign ts_valid = ~fifo_empty;
    assign busy     = (state == ST_WAIT);
    assign lost     = fsm_push && fifo_full && !pop;
    assign drop_inc = fsm_drops + {1'b0, lost};

    always_ff @(posedge clk) begin
        if (rst) begin
            coarse     <= '0;
            state      <= ST_IDLE;
            coarse_lat <= '0;
            wait_cnt   <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            coarse     <= coarse + COARSE_W'(1);
            state      <= state_next;
            coarse_lat <= coarse_lat_next;
            wait_cnt   <= wait_cnt_next;
            overflow   <= overflow | lost;
            drop_count <= sat_add16(drop_count, drop_inc);
        end
    end

    always_comb begin
        state_next      = state;
        coarse_lat_next = coarse_lat;
        wait_cnt_next   = wait_cnt;
        fsm_push        = 1'b0;
        fsm_drops       = 2'd0;
        case (state)
            ST_IDLE: begin
                if (hit_go) begin
                    state_next      = ST_WAIT;
                    coarse_lat_next = coarse;
                    wait_cnt_next   = '0;
                end
            end
            ST_WAIT: begin
                if (dec_finished) begin
                    fsm_push   = 1'b1;
                    state_next = ST_IDLE;
                    fsm_drops  = {1'b0, hit_go};
                end else begin
                    wait_cnt_next = wait_cnt + WCNT_W'(1);
                    if (wait_cnt == WCNT_W'(TIMEOUT - 1)) begin
                        // Timed-out hit is lost, plus any hit arriving now.
                        state_next = ST_IDLE;
                        fsm_drops  = hit_go ? 2'd2 : 2'd1;
                    end else begin
                        fsm_drops  = {1'b0, hit_go};
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    ts_fifo #(
        .WIDTH(COARSE_W + FINE_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (fsm_push),
        .pop  (pop),
        .din  ({coarse_lat, dec_code}),
        .dout (ts_data),
        .empty(fifo_empty),
        .full (fifo_full)
    );

endmodule
